// File: rtl/mem_arbiter_if.sv
// -----------------------------------------------------------------------------
// mem_arbiter_if
// Purpose : bundles the instruction-fetch port, the data port and the command /
//           read-data path of a single-port synchronous RAM into one interface.
// Signals :
//   i_req, i_addr[31:0]                 instruction read request
//   i_gnt, i_rvalid, i_rdata[31:0]      instruction grant and read response
//   d_req, d_we, d_addr[31:0],
//   d_wdata[31:0], d_lock               data request (lock = atomic RMW hold)
//   d_gnt, d_rvalid, d_rdata[31:0]      data grant and read response
//   m_en, m_we, m_addr[31:0],
//   m_wdata[31:0]                       RAM command
//   m_rdata[31:0]                       RAM read data, one cycle after a read
// Modports: slave  = the arbiter's view
//           master = the requesters' and RAM's view
// -----------------------------------------------------------------------------
interface mem_arbiter_if;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_gnt;
  logic        i_rvalid;
  logic [31:0] i_rdata;

  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_lock;
  logic        d_gnt;
  logic        d_rvalid;
  logic [31:0] d_rdata;

  logic        m_en;
  logic        m_we;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [31:0] m_rdata;

  modport slave (
    input  i_req, i_addr,
    input  d_req, d_we, d_addr, d_wdata, d_lock,
    input  m_rdata,
    output i_gnt, i_rvalid, i_rdata,
    output d_gnt, d_rvalid, d_rdata,
    output m_en, m_we, m_addr, m_wdata
  );

  modport master (
    output i_req, i_addr,
    output d_req, d_we, d_addr, d_wdata, d_lock,
    output m_rdata,
    input  i_gnt, i_rvalid, i_rdata,
    input  d_gnt, d_rvalid, d_rdata,
    input  m_en, m_we, m_addr, m_wdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
// Purpose : arbitrates an instruction-fetch port and a data port onto one
//           single-port synchronous RAM. Data wins by default, the instruction
//           port wins after STARVE_MAX consecutive denied cycles, and the data
//           port may hold a lock (atomic read-modify-write) for at most
//           LOCK_MAX cycles. Read responses are routed back to the port that
//           issued the read, one cycle after the grant.
// Ports   :
//   clk      in   single clock, rising edge
//   reset_n  in   asynchronous active-low reset
//   bus      slave modport of mem_arbiter_if (request, grant, response and
//            RAM command signals)
// Parameters:
//   STARVE_MAX  denied instruction cycles before the instruction port is forced
//   LOCK_MAX    maximum cycles the data port may hold a lock
// -----------------------------------------------------------------------------
module mem_arbiter #(
  parameter int STARVE_MAX = 3,
  parameter int LOCK_MAX   = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  mem_arbiter_if.slave bus
);

  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam int LW = $clog2(LOCK_MAX + 1);

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t        r_state;
  state_t        w_state_next;
  logic [SW-1:0] r_starve_cnt;
  logic [SW-1:0] w_starve_next;
  logic [LW-1:0] r_lock_cnt;
  logic [LW-1:0] w_lock_next;
  logic          r_resp_pend;
  logic          r_resp_owner_d;   // 1: response belongs to the data port

  logic          w_lock_held;
  logic          w_forced;
  logic          w_starved;
  logic          w_i_gnt;
  logic          w_d_gnt;

  // Next-state, grant and counter logic
  always_comb begin
    w_i_gnt      = 1'b0;
    w_d_gnt      = 1'b0;
    w_state_next = r_state;
    w_lock_next  = r_lock_cnt;

    // d_lock is meaningless without d_req, so the lock only counts as held
    // while the data port is actually requesting.
    w_lock_held = bus.d_req & bus.d_lock;
    // Lock still held but its budget is used up: release this cycle and keep
    // the data port from re-locking in the same cycle.
    w_forced    = (r_state == LOCKED) & w_lock_held &
                  (r_lock_cnt == LW'(LOCK_MAX));
    w_starved   = bus.i_req & (r_starve_cnt == SW'(STARVE_MAX));

    if ((r_state == LOCKED) && w_lock_held && !w_forced) begin
      w_d_gnt     = 1'b1;
      w_lock_next = r_lock_cnt + 1'b1;
    end else begin
      // IDLE arbitration, also used in the cycle a lock is released
      if (bus.i_req && (w_forced || w_starved)) begin
        w_i_gnt = 1'b1;
      end else if (bus.d_req) begin
        w_d_gnt = 1'b1;
      end else if (bus.i_req) begin
        w_i_gnt = 1'b1;
      end

      if (w_d_gnt && w_lock_held && !w_forced) begin
        w_state_next = LOCKED;
        w_lock_next  = LW'(1);
      end else begin
        w_state_next = IDLE;
        w_lock_next  = '0;
      end
    end

    if (bus.i_req && !w_i_gnt) begin
      w_starve_next = (r_starve_cnt == SW'(STARVE_MAX)) ? r_starve_cnt
                                                        : r_starve_cnt + 1'b1;
    end else begin
      w_starve_next = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state        <= IDLE;
      r_starve_cnt   <= '0;
      r_lock_cnt     <= '0;
      r_resp_pend    <= 1'b0;
      r_resp_owner_d <= 1'b0;
    end else begin
      r_state        <= w_state_next;
      r_starve_cnt   <= w_starve_next;
      r_lock_cnt     <= w_lock_next;
      r_resp_pend    <= w_i_gnt | (w_d_gnt & ~bus.d_we);
      r_resp_owner_d <= w_d_gnt;
    end
  end

  // Combinational outputs are gated so everything reads 0 while in reset.
  assign bus.i_gnt    = reset_n & w_i_gnt;
  assign bus.d_gnt    = reset_n & w_d_gnt;
  assign bus.m_en     = reset_n & (w_i_gnt | w_d_gnt);
  assign bus.m_we     = reset_n & w_d_gnt & bus.d_we;
  assign bus.m_addr   = !reset_n ? 32'h0 :
                        w_i_gnt  ? bus.i_addr :
                        w_d_gnt  ? bus.d_addr : 32'h0;
  assign bus.m_wdata  = (reset_n & w_d_gnt) ? bus.d_wdata : 32'h0;

  assign bus.i_rvalid = r_resp_pend & ~r_resp_owner_d;
  assign bus.d_rvalid = r_resp_pend &  r_resp_owner_d;
  assign bus.i_rdata  = reset_n ? bus.m_rdata : 32'h0;
  assign bus.d_rdata  = reset_n ? bus.m_rdata : 32'h0;

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
// Purpose : self-checking bench for mem_arbiter. A small RAM answers the DUT's
//           commands; a reference model of the arbitration rules and of the
//           memory contents checks every output on every falling edge.
//           Directed sequences pin the model with literal expectations,
//           followed by randomized traffic.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;
  localparam int STARVE_MAX = 3;
  localparam int LOCK_MAX   = 8;

  logic clk = 1'b0;
  logic reset_n;
  int   n_checks = 0;
  int   n_fail   = 0;

  mem_arbiter_if bus ();

  mem_arbiter #(
    .STARVE_MAX(STARVE_MAX),
    .LOCK_MAX  (LOCK_MAX)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(input int i);
    return 32'hC0DE_0000 | 32'(i);
  endfunction

  // RAM seen by the DUT: registered read, one cycle latency
  logic [31:0] ram [64];
  always @(posedge clk) begin
    if (bus.m_en) begin
      if (bus.m_we) ram[bus.m_addr[7:2]] <= bus.m_wdata;
      else          bus.m_rdata <= ram[bus.m_addr[7:2]];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model + compare process
  // ---------------------------------------------------------------------------
  initial begin : compare
    logic [31:0] ref_mem [64];
    int          starve;
    int          lock_grants;   // grants issued under the current lock
    bit          locked;
    bit          pend, pend_d;
    logic [31:0] pend_data;
    bit          ir, dr, dw, lk, forced, eg_i, eg_d;
    logic [31:0] e_addr, e_wdata;

    for (int k = 0; k < 64; k++) ref_mem[k] = init_word(k);
    starve = 0; lock_grants = 0; locked = 0; pend = 0; pend_d = 0; pend_data = '0;

    forever begin
      @(negedge clk);
      if (reset_n !== 1'b1) begin
        chk("rst_i_gnt",    32'(bus.i_gnt),    0);
        chk("rst_d_gnt",    32'(bus.d_gnt),    0);
        chk("rst_i_rvalid", 32'(bus.i_rvalid), 0);
        chk("rst_d_rvalid", 32'(bus.d_rvalid), 0);
        chk("rst_m_en",     32'(bus.m_en),     0);
        chk("rst_m_we",     32'(bus.m_we),     0);
        chk("rst_m_addr",   bus.m_addr,        0);
        chk("rst_m_wdata",  bus.m_wdata,       0);
        chk("rst_i_rdata",  bus.i_rdata,       0);
        chk("rst_d_rdata",  bus.d_rdata,       0);
        starve = 0; lock_grants = 0; locked = 0; pend = 0; pend_d = 0;
      end else begin
        ir = bus.i_req;
        dr = bus.d_req;
        dw = dr & bus.d_we;
        lk = dr & bus.d_lock;

        // responses from the previous cycle's grant
        chk("i_rvalid", 32'(bus.i_rvalid), 32'(pend && !pend_d));
        chk("d_rvalid", 32'(bus.d_rvalid), 32'(pend && pend_d));
        if (pend) begin
          if (pend_d) chk("d_rdata", bus.d_rdata, pend_data);
          else        chk("i_rdata", bus.i_rdata, pend_data);
        end

        // who wins this cycle
        eg_i = 0; eg_d = 0;
        forced = locked && lk && (lock_grants >= LOCK_MAX);
        if (locked && lk && !forced)                        eg_d = 1;
        else if (ir && (forced || starve >= STARVE_MAX))    eg_i = 1;
        else if (dr)                                        eg_d = 1;
        else if (ir)                                        eg_i = 1;

        e_addr  = eg_i ? bus.i_addr : (eg_d ? bus.d_addr : 32'h0);
        e_wdata = eg_d ? bus.d_wdata : 32'h0;
        chk("i_gnt",   32'(bus.i_gnt), 32'(eg_i));
        chk("d_gnt",   32'(bus.d_gnt), 32'(eg_d));
        chk("m_en",    32'(bus.m_en),  32'(eg_i | eg_d));
        chk("m_we",    32'(bus.m_we),  32'(eg_d & dw));
        chk("m_addr",  bus.m_addr,  e_addr);
        chk("m_wdata", bus.m_wdata, e_wdata);

        // advance the model to the next cycle
        pend      = eg_i || (eg_d && !dw);
        pend_d    = eg_d;
        pend_data = ref_mem[e_addr[7:2]];
        if (eg_d && dw) ref_mem[e_addr[7:2]] = e_wdata;

        if (locked && lk && !forced) begin
          lock_grants++;
        end else if (eg_d && lk && !forced) begin
          locked = 1; lock_grants = 1;
        end else begin
          locked = 0; lock_grants = 0;
        end

        if (ir && !eg_i) starve = (starve < STARVE_MAX) ? starve + 1 : starve;
        else             starve = 0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  task automatic drive(input bit ir, input logic [31:0] ia, input bit dr, input bit dw,
                       input bit dl, input logic [31:0] da, input logic [31:0] dd);
    @(posedge clk);
    #1;
    bus.i_req = ir;  bus.i_addr = ia;
    bus.d_req = dr;  bus.d_we = dw;  bus.d_lock = dl;
    bus.d_addr = da; bus.d_wdata = dd;
  endtask

  task automatic idle();
    drive(0, 32'h0, 0, 0, 0, 32'h0, 32'h0);
  endtask

  task automatic set_idle_now();
    bus.i_req = 0; bus.i_addr = 0;
    bus.d_req = 0; bus.d_we = 0; bus.d_lock = 0;
    bus.d_addr = 0; bus.d_wdata = 0;
  endtask

  initial begin : stim
    for (int k = 0; k < 64; k++) ram[k] = init_word(k);

    // reset with requests asserted: outputs must stay 0
    reset_n = 1'b0;
    bus.i_req = 1; bus.i_addr = 32'h8;
    bus.d_req = 1; bus.d_we = 1; bus.d_lock = 1;
    bus.d_addr = 32'h44; bus.d_wdata = 32'h1234_5678;
    repeat (2) @(negedge clk);
    #2;
    set_idle_now();
    reset_n = 1'b1;

    // simultaneous read, data wins
    $display("txn: simultaneous read i@0x0 d@0x40");
    drive(1, 32'h0, 1, 0, 0, 32'h40, 32'h0);
    @(negedge clk);
    chk("sim_d_gnt",  32'(bus.d_gnt), 1);
    chk("sim_i_gnt",  32'(bus.i_gnt), 0);
    chk("sim_m_addr", bus.m_addr, 32'h40);
    idle();
    @(negedge clk);
    chk("sim_d_rvalid", 32'(bus.d_rvalid), 1);
    chk("sim_i_rvalid", 32'(bus.i_rvalid), 0);
    chk("sim_d_rdata",  bus.d_rdata, 32'hC0DE_0010);

    // starvation: d, d, d, i, d
    $display("txn: starvation sequence");
    for (int k = 0; k < 5; k++) begin
      drive(1, 32'h100 + 32'(k * 4), 1, 0, 0, 32'h80 + 32'(k * 4), 32'h0);
      @(negedge clk);
      chk("starve_i_gnt", 32'(bus.i_gnt), 32'(k == 3));
      chk("starve_d_gnt", 32'(bus.d_gnt), 32'(k != 3));
    end
    idle();

    // lock for 5 cycles, then drop
    $display("txn: 5-cycle lock then release");
    for (int k = 0; k < 5; k++) begin
      drive(1, 32'h20, 1, k[0], 1, 32'h30, 32'hA0 + 32'(k));
      @(negedge clk);
      chk("lock_i_gnt", 32'(bus.i_gnt), 0);
      chk("lock_d_gnt", 32'(bus.d_gnt), 1);
    end
    drive(1, 32'h20, 0, 0, 0, 32'h0, 32'h0);
    @(negedge clk);
    chk("unlock_i_gnt", 32'(bus.i_gnt), 1);
    idle();

    // forced release at LOCK_MAX
    $display("txn: 12-cycle lock, forced release");
    for (int k = 0; k < 12; k++) begin
      drive(1, 32'h24, 1, 0, 1, 32'h34, 32'h0);
      @(negedge clk);
      chk("force_i_gnt", 32'(bus.i_gnt), 32'(k == 8));
      chk("force_d_gnt", 32'(bus.d_gnt), 32'(k != 8));
    end
    idle();

    // write, then read it back
    $display("txn: write 0xDEADBEEF to 0x10");
    drive(0, 32'h0, 1, 1, 0, 32'h10, 32'hDEAD_BEEF);
    @(negedge clk);
    chk("wr_m_we",    32'(bus.m_we), 1);
    chk("wr_m_wdata", bus.m_wdata, 32'hDEAD_BEEF);
    chk("wr_m_addr",  bus.m_addr,  32'h10);
    drive(0, 32'h0, 1, 0, 0, 32'h10, 32'h0);
    @(negedge clk);
    chk("wr_no_d_rvalid", 32'(bus.d_rvalid), 0);
    chk("wr_no_i_rvalid", 32'(bus.i_rvalid), 0);
    idle();
    @(negedge clk);
    chk("rb_d_rvalid", 32'(bus.d_rvalid), 1);
    chk("rb_d_rdata",  bus.d_rdata, 32'hDEAD_BEEF);

    // reset while a read is in flight
    $display("txn: reset during instruction read");
    drive(1, 32'h24, 0, 0, 0, 32'h0, 32'h0);
    @(negedge clk);
    chk("rst_rd_i_gnt", 32'(bus.i_gnt), 1);
    #2;
    reset_n = 1'b0;
    @(negedge clk);
    #2;
    set_idle_now();
    reset_n = 1'b1;
    #1;
    chk("post_rst_i_rvalid", 32'(bus.i_rvalid), 0);
    chk("post_rst_d_rvalid", 32'(bus.d_rvalid), 0);
    // first cycle out of reset: grant immediately, counters start at 0
    drive(1, 32'h4, 1, 0, 0, 32'h8, 32'h0);
    @(negedge clk);
    chk("first_d_gnt", 32'(bus.d_gnt), 1);
    idle();

    // randomized traffic: first half lock-heavy, second half mixed
    $display("txn: randomized traffic");
    for (int k = 0; k < 3000; k++) begin
      int pd, pl;
      pd = (k < 1500) ? 90 : 60;
      pl = (k < 1500) ? 90 : 30;
      drive($urandom_range(0, 99) < 60, $urandom, $urandom_range(0, 99) < pd,
            $urandom_range(0, 99) < 30, $urandom_range(0, 99) < pl, $urandom, $urandom);
    end
    idle();
    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
